// File: rtl/subr8u_serial.sv
// subr8u_serial: bit-serial unsigned subtractor, D = S - A, using one full-subtractor cell.
// Operands are latched, rotated LSB-first through the cell, and the result is shifted in from the MSB side.
// Optional self-check (re-add result and compare to S) is enabled by defining SUBR8U_SERIAL_CHECK_EN.
module subr8u_serial #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   s,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             range_err,
    output logic             err
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   s_q, s_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH:0]   r_q, r_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             range_err_q, range_err_d;
    logic             bit_r;
    logic             bit_b;

`ifdef SUBR8U_SERIAL_CHECK_EN
    logic             err_q, err_d;
    logic [WIDTH:0]   chk_sum;
`endif

    // Full-subtractor cell on the current LSB of the rotating operand registers.
    always_comb begin
        bit_r = s_q[0] ^ a_q[0] ^ borrow_q;
        bit_b = (~s_q[0] & a_q[0]) | (~(s_q[0] ^ a_q[0]) & borrow_q);
    end

    // Next-state and datapath: operands rotate so they are restored after WIDTH+1 shifts.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        a_d         = a_q;
        r_d         = r_q;
        borrow_d    = borrow_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        d_d         = d_q;
        range_err_d = range_err_q;
`ifdef SUBR8U_SERIAL_CHECK_EN
        err_d       = err_q;
        chk_sum     = '0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    s_d        = s;
                    a_d        = {1'b0, a};
                    r_d        = '0;
                    borrow_d   = 1'b0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                s_d      = {s_q[0], s_q[WIDTH:1]};
                a_d      = {a_q[0], a_q[WIDTH:1]};
                r_d      = {bit_r, r_q[WIDTH:1]};
                borrow_d = bit_b;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    d_d         = r_d[WIDTH-1:0];
                    range_err_d = bit_r | bit_b;
`ifdef SUBR8U_SERIAL_CHECK_EN
                    // Independent parallel re-add of the result against the restored operands.
                    chk_sum     = r_d + a_d;
                    err_d       = (chk_sum != s_d);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
`ifdef SUBR8U_SERIAL_CHECK_EN
                    err_d       = 1'b0;
`endif
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            a_q         <= '0;
            r_q         <= '0;
            borrow_q    <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            d_q         <= '0;
            range_err_q <= 1'b0;
`ifdef SUBR8U_SERIAL_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            a_q         <= a_d;
            r_q         <= r_d;
            borrow_q    <= borrow_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            d_q         <= d_d;
            range_err_q <= range_err_d;
`ifdef SUBR8U_SERIAL_CHECK_EN
            err_q       <= err_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign range_err = range_err_q;
`ifdef SUBR8U_SERIAL_CHECK_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_subr8u_serial.sv
// Directed bench for subr8u_serial: latency, arithmetic vectors, reset, backpressure, streaming, checker.
module tb_subr8u_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] s;
    logic [7:0] a;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] d;
    logic       range_err;
    logic       err;

    int n_chk  = 0;
    int n_fail = 0;

    subr8u_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .range_err (range_err),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present an operand pair in IDLE and take the accepting edge.
    task automatic start_op(input logic [8:0] sv, input logic [7:0] av);
        s        = sv;
        a        = av;
        in_valid = 1'b1;
        chk("ready_before_accept", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Count cycles from the accepting edge until out_valid, bounded.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_err", 32'(err), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [8:0] sv, input logic [7:0] av,
                          input logic [7:0] exp_d, input logic exp_re);
        int lat;
        start_op(sv, av);
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        wait_valid(lat);
        chk({tag, "_latency"}, 32'(lat), 32'd9);
        chk({tag, "_d"}, 32'(d), 32'(exp_d));
        chk({tag, "_range_err"}, 32'(range_err), 32'(exp_re));
        chk({tag, "_err"}, 32'(err), 32'd0);
        handshake();
    endtask

    initial begin
        int lat;
        int acc[$];

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        s         = '0;
        a         = '0;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_range_err", 32'(range_err), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        step();

        // Arithmetic vectors: 300-45=255; 5-10 wraps to 0x1FB; 510-255=255; 511-0=511.
        run_op("nominal", 9'h12C, 8'h2D, 8'hFF, 1'b0);
        run_op("underflow", 9'h005, 8'h0A, 8'hFB, 1'b1);
        run_op("edge_1fe", 9'h1FE, 8'hFF, 8'hFF, 1'b0);
        run_op("edge_1ff", 9'h1FF, 8'h00, 8'hFF, 1'b1);

        // Reset during SHIFT cycle 4 clears outputs (d held 0xFF before) immediately.
        start_op(9'h0F0, 8'h01);
        step();
        step();
        step();
        chk("mid_busy", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_d", 32'(d), 32'd0);
        step();
        rst = 1'b0;
        step();
        run_op("after_rst", 9'h00A, 8'h03, 8'h07, 1'b0);

        // Backpressure: result held while a second request waits.
        start_op(9'h12C, 8'h2D);
        wait_valid(lat);
        chk("bp_latency", 32'(lat), 32'd9);
        s        = 9'h055;
        a        = 8'h11;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_d_stable", 32'(d), 32'hFF);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end

        // Streaming: accepts land every 11 cycles.
        out_ready = 1'b1;
        for (int i = 0; i < 44; i++) begin
            if (in_ready) acc.push_back(i);
            step();
        end
        chk("stream_accepts", 32'(acc.size() >= 3), 32'd1);
        if (acc.size() >= 3) begin
            chk("stream_gap0", 32'(acc[1] - acc[0]), 32'd11);
            chk("stream_gap1", 32'(acc[2] - acc[1]), 32'd11);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wait_valid(lat);
        chk("stream_valid", 32'(out_valid), 32'd1);
        chk("stream_d", 32'(d), 32'h44);
        chk("stream_range_err", 32'(range_err), 32'd0);
        handshake();

`ifdef SUBR8U_SERIAL_CHECK_EN
        // Flip final r[3] (held in r_q[4] before the last shift): d becomes 0xF7 and the re-add mismatches.
        start_op(9'h12C, 8'h2D);
        for (int i = 0; i < 8; i++) step();
        force dut.r_q = 9'h1EE;
        step();
        release dut.r_q;
        chk("chk_valid", 32'(out_valid), 32'd1);
        chk("chk_d_flipped", 32'(d), 32'hF7);
        chk("chk_err_set", 32'(err), 32'd1);
        handshake();
        run_op("chk_clean", 9'h12C, 8'h2D, 8'hFF, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach end of sequence");
        $fatal(1, "timeout");
    end

endmodule
